// File: rtl/ahb_arb_pkg.sv
// ahb_arb_pkg
//   Shared types for the two-master AHB-Lite SDRAM arbiter:
//   HTRANS encodings, arbiter FSM state encoding and the buffered
//   address-phase record held per master.
package ahb_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Width of the address field kept in the hold buffer; the ports cast
    // to/from it, so keep it >= the top-level ADDR_W.
    localparam int ARB_ADDR_W = 32;

    typedef enum logic {
        ST_ARB  = 1'b0,   // slave idle, offering the granted request
        ST_DATA = 1'b1    // slave data phase for the current owner
    } arb_state_e;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic                  write;
        logic [2:0]            size;
        logic [2:0]            burst;
    } arb_req_t;

endpackage

// File: rtl/ahb_lite_arb_req_buf.sv
// ahb_lite_arb_req_buf
//   Per-master address-phase hold buffer and stall logic.
//   Ports:
//     HCLK, HRESETn         clock, synchronous active-low reset
//     hsel/haddr/htrans/    master address phase
//     hwrite/hsize/hburst
//     own_data              this master owns the current slave data phase
//     s_hready, s_hresp     slave handshake, used only while own_data
//     pend, req             buffered request waiting for / in service
//     hready, hresp         master-facing handshake
import ahb_arb_pkg::*;

module ahb_lite_arb_req_buf #(
    parameter int ADDR_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    input  logic              own_data,
    input  logic              s_hready,
    input  logic              s_hresp,
    output logic              pend,
    output arb_req_t          req,
    output logic              hready,
    output logic              hresp
);

    logic capture;
    logic done;

    // The owner sees the slave handshake verbatim (including both ERROR
    // cycles); otherwise a pending request simply stalls the master.
    always_comb begin
        if (own_data) begin
            hready = s_hready;
            hresp  = s_hresp;
        end else begin
            hready = !pend;
            hresp  = 1'b0;
        end
    end

    assign capture = hsel && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ) && hready;
    assign done    = own_data && s_hready;

    // Completion clears first so a request captured in the completion
    // cycle survives.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            pend <= 1'b0;
            req  <= '0;
        end else begin
            if (done)
                pend <= 1'b0;
            if (capture) begin
                pend      <= 1'b1;
                req.addr  <= ARB_ADDR_W'(haddr);
                req.write <= hwrite;
                req.size  <= hsize;
                req.burst <= hburst;
            end
        end
    end

endmodule

// File: rtl/ahb_lite_sdram_arbiter.sv
// ahb_lite_sdram_arbiter
//   Two-master AHB-Lite arbiter in front of a single SDRAM slave.
//   Each master's address phase is buffered, then replayed to the slave
//   one transfer at a time (non-pipelined) under round-robin arbitration.
//   Ports:
//     HCLK, HRESETn                 clock, synchronous active-low reset
//     Mi_HSEL..Mi_HWDATA (i=0,1)    master request inputs
//     Mi_HRDATA/HREADY/HRESP        master responses
//     S_HSEL..S_HWDATA              slave request
//     S_HRDATA/HREADY/HRESP         slave response
//   Build option: AHB_ARB_FIXED_PRIORITY_EN gives M0 every tie instead of
//   round-robin.
import ahb_arb_pkg::*;

module ahb_lite_sdram_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              M0_HSEL,
    input  logic [ADDR_W-1:0] M0_HADDR,
    input  logic [1:0]        M0_HTRANS,
    input  logic              M0_HWRITE,
    input  logic [2:0]        M0_HSIZE,
    input  logic [2:0]        M0_HBURST,
    input  logic [DATA_W-1:0] M0_HWDATA,
    output logic [DATA_W-1:0] M0_HRDATA,
    output logic              M0_HREADY,
    output logic              M0_HRESP,
    input  logic              M1_HSEL,
    input  logic [ADDR_W-1:0] M1_HADDR,
    input  logic [1:0]        M1_HTRANS,
    input  logic              M1_HWRITE,
    input  logic [2:0]        M1_HSIZE,
    input  logic [2:0]        M1_HBURST,
    input  logic [DATA_W-1:0] M1_HWDATA,
    output logic [DATA_W-1:0] M1_HRDATA,
    output logic              M1_HREADY,
    output logic              M1_HRESP,
    output logic              S_HSEL,
    output logic [ADDR_W-1:0] S_HADDR,
    output logic [1:0]        S_HTRANS,
    output logic              S_HWRITE,
    output logic [2:0]        S_HSIZE,
    output logic [2:0]        S_HBURST,
    output logic [DATA_W-1:0] S_HWDATA,
    input  logic [DATA_W-1:0] S_HRDATA,
    input  logic              S_HREADY,
    input  logic              S_HRESP
);

    localparam int NUM_M = 2;

    logic [NUM_M-1:0]             m_hsel, m_hwrite, m_hready, m_hresp;
    logic [NUM_M-1:0][ADDR_W-1:0] m_haddr;
    logic [NUM_M-1:0][1:0]        m_htrans;
    logic [NUM_M-1:0][2:0]        m_hsize, m_hburst;
    logic [NUM_M-1:0][DATA_W-1:0] m_hwdata, m_hrdata;
    logic [NUM_M-1:0]             pend, own_data;
    arb_req_t [NUM_M-1:0]         req;

    arb_state_e state, state_nxt;
    logic       owner;
    logic       gnt, tie_gnt;
    logic       hold_vld, hold_gnt;

    assign m_hsel   = {M1_HSEL,   M0_HSEL};
    assign m_haddr  = {M1_HADDR,  M0_HADDR};
    assign m_htrans = {M1_HTRANS, M0_HTRANS};
    assign m_hwrite = {M1_HWRITE, M0_HWRITE};
    assign m_hsize  = {M1_HSIZE,  M0_HSIZE};
    assign m_hburst = {M1_HBURST, M0_HBURST};
    assign m_hwdata = {M1_HWDATA, M0_HWDATA};

    assign M0_HRDATA = m_hrdata[0];
    assign M1_HRDATA = m_hrdata[1];
    assign M0_HREADY = m_hready[0];
    assign M1_HREADY = m_hready[1];
    assign M0_HRESP  = m_hresp[0];
    assign M1_HRESP  = m_hresp[1];

    for (genvar g = 0; g < NUM_M; g++) begin : g_m
        ahb_lite_arb_req_buf #(.ADDR_W(ADDR_W)) u_buf (
            .HCLK     (HCLK),
            .HRESETn  (HRESETn),
            .hsel     (m_hsel[g]),
            .haddr    (m_haddr[g]),
            .htrans   (m_htrans[g]),
            .hwrite   (m_hwrite[g]),
            .hsize    (m_hsize[g]),
            .hburst   (m_hburst[g]),
            .own_data (own_data[g]),
            .s_hready (S_HREADY),
            .s_hresp  (S_HRESP),
            .pend     (pend[g]),
            .req      (req[g]),
            .hready   (m_hready[g]),
            .hresp    (m_hresp[g])
        );
        assign m_hrdata[g] = own_data[g] ? S_HRDATA : '0;
    end

`ifdef AHB_ARB_FIXED_PRIORITY_EN
    assign tie_gnt = 1'b0;
`else
    logic last_grant;

    always_ff @(posedge HCLK) begin
        if (!HRESETn)
            last_grant <= 1'b1;
        else if (state == ST_DATA && S_HREADY)
            last_grant <= owner;
    end

    assign tie_gnt = !last_grant;
`endif

    // A grant offered to a waiting slave is frozen so a late arrival on the
    // other master cannot swap the address mid-offer.
    always_comb begin
        if (hold_vld)
            gnt = hold_gnt;
        else if (pend == 2'b10)
            gnt = 1'b1;
        else if (pend == 2'b01)
            gnt = 1'b0;
        else
            gnt = tie_gnt;
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn)
            state <= ST_ARB;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ARB:  if (|pend && S_HREADY) state_nxt = ST_DATA;
            ST_DATA: if (S_HREADY)          state_nxt = ST_ARB;
            default: state_nxt = ST_ARB;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            owner    <= 1'b0;
            hold_vld <= 1'b0;
            hold_gnt <= 1'b0;
        end else if (state == ST_ARB && |pend) begin
            if (S_HREADY) begin
                owner    <= gnt;
                hold_vld <= 1'b0;
            end else begin
                hold_vld <= 1'b1;
                hold_gnt <= gnt;
            end
        end
    end

    always_comb begin
        S_HSEL   = 1'b0;
        S_HADDR  = '0;
        S_HTRANS = HTRANS_IDLE;
        S_HWRITE = 1'b0;
        S_HSIZE  = '0;
        S_HBURST = '0;
        S_HWDATA = '0;
        own_data = '0;
        case (state)
            ST_ARB: begin
                if (|pend) begin
                    S_HSEL   = 1'b1;
                    S_HTRANS = HTRANS_NONSEQ;
                    S_HADDR  = ADDR_W'(req[gnt].addr);
                    S_HWRITE = req[gnt].write;
                    S_HSIZE  = req[gnt].size;
                    S_HBURST = req[gnt].burst;
                end
            end
            ST_DATA: begin
                S_HWDATA        = m_hwdata[owner];
                own_data[owner] = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahb_lite_sdram_arbiter.sv
module tb_ahb_lite_sdram_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
`ifdef AHB_ARB_FIXED_PRIORITY_EN
    localparam int RR_TIE = 0;
`else
    localparam int RR_TIE = 1;
`endif

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          M0_HSEL, M1_HSEL, M0_HWRITE, M1_HWRITE;
    logic [AW-1:0] M0_HADDR, M1_HADDR;
    logic [1:0]    M0_HTRANS, M1_HTRANS;
    logic [2:0]    M0_HSIZE, M1_HSIZE, M0_HBURST, M1_HBURST;
    logic [DW-1:0] M0_HWDATA, M1_HWDATA, M0_HRDATA, M1_HRDATA;
    logic          M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP;
    logic          S_HSEL, S_HWRITE, S_HREADY, S_HRESP;
    logic [AW-1:0] S_HADDR;
    logic [1:0]    S_HTRANS;
    logic [2:0]    S_HSIZE, S_HBURST;
    logic [DW-1:0] S_HWDATA, S_HRDATA;

    always #5 HCLK = ~HCLK;

    ahb_lite_sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .M0_HSEL(M0_HSEL), .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE),
        .M0_HSIZE(M0_HSIZE), .M0_HBURST(M0_HBURST), .M0_HWDATA(M0_HWDATA),
        .M0_HRDATA(M0_HRDATA), .M0_HREADY(M0_HREADY), .M0_HRESP(M0_HRESP),
        .M1_HSEL(M1_HSEL), .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE),
        .M1_HSIZE(M1_HSIZE), .M1_HBURST(M1_HBURST), .M1_HWDATA(M1_HWDATA),
        .M1_HRDATA(M1_HRDATA), .M1_HREADY(M1_HREADY), .M1_HRESP(M1_HRESP),
        .S_HSEL(S_HSEL), .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE),
        .S_HSIZE(S_HSIZE), .S_HBURST(S_HBURST), .S_HWDATA(S_HWDATA),
        .S_HRDATA(S_HRDATA), .S_HREADY(S_HREADY), .S_HRESP(S_HRESP)
    );

    // Small SDRAM slave: programmable wait states and two-cycle ERROR.
    logic [DW-1:0] mem [16];
    logic          dp_vld, dp_write, dp_err, err_ph;
    logic [3:0]    dp_idx;
    int            wait_cnt;
    int            cfg_wait;
    logic          cfg_err;

    always_comb begin
        S_HREADY = 1'b1;
        S_HRESP  = 1'b0;
        S_HRDATA = '0;
        if (dp_vld) begin
            if (wait_cnt > 0)
                S_HREADY = 1'b0;
            else if (dp_err) begin
                S_HRESP  = 1'b1;
                S_HREADY = err_ph;
            end else if (!dp_write)
                S_HRDATA = mem[dp_idx];
        end
    end

    always @(posedge HCLK) begin
        if (!HRESETn) begin
            dp_vld   <= 1'b0;
            err_ph   <= 1'b0;
            wait_cnt <= 0;
        end else if (dp_vld) begin
            if (wait_cnt > 0)
                wait_cnt <= wait_cnt - 1;
            else if (dp_err && !err_ph)
                err_ph <= 1'b1;
            else begin
                dp_vld <= 1'b0;
                if (dp_write) mem[dp_idx] <= S_HWDATA;
            end
        end else if (S_HSEL && S_HTRANS[1] && S_HREADY) begin
            dp_vld   <= 1'b1;
            dp_write <= S_HWRITE;
            dp_idx   <= S_HADDR[5:2];
            dp_err   <= cfg_err;
            err_ph   <= 1'b0;
            wait_cnt <= cfg_wait;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge HCLK); #1;
    endtask

    task automatic smp();
        @(negedge HCLK);
    endtask

    task automatic m_drv(input int m, input logic sel, input logic [1:0] tr,
                         input logic wr, input logic [31:0] a);
        if (m == 0) begin
            M0_HSEL = sel; M0_HTRANS = tr; M0_HWRITE = wr; M0_HADDR = a;
        end else begin
            M1_HSEL = sel; M1_HTRANS = tr; M1_HWRITE = wr; M1_HADDR = a;
        end
    endtask

    task automatic m_wd(input int m, input logic [31:0] d);
        if (m == 0) M0_HWDATA = d; else M1_HWDATA = d;
    endtask

    function automatic logic hr(input int m);
        return (m == 1) ? M1_HREADY : M0_HREADY;
    endfunction

    function automatic logic [31:0] rd(input int m);
        return (m == 1) ? M1_HRDATA : M0_HRDATA;
    endfunction

    // One isolated transfer: capture, slave address phase, data phase.
    task automatic single(input int m, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd);
        nxt(); m_drv(m, 1'b1, 2'b10, wr, a);
        smp(); chk("single_cap_rdy", hr(m), 1);
        nxt(); m_drv(m, 1'b0, 2'b00, 1'b0, 0); m_wd(m, d);
        smp(); chk("single_s_addr", S_HADDR, a);
        chk("single_s_trans", S_HTRANS, 2);
        chk("single_s_write", S_HWRITE, wr);
        chk("single_stall", hr(m), 0);
        nxt();
        smp(); chk("single_done_rdy", hr(m), 1);
        chk("single_data_trans", S_HTRANS, 0);
        if (wr) chk("single_s_wdata", S_HWDATA, d);
        else    chk("single_rdata", rd(m), exp_rd);
    endtask

    // Both masters request in the same cycle; 'first' is the expected winner.
    task automatic tie(input logic [31:0] a0, input logic [31:0] d0,
                       input logic [31:0] a1, input logic [31:0] d1, input int first);
        int oth;
        logic [31:0] af, ao, df, dother;
        oth    = 1 - first;
        af     = (first == 1) ? a1 : a0;
        ao     = (first == 1) ? a0 : a1;
        df     = (first == 1) ? d1 : d0;
        dother = (first == 1) ? d0 : d1;
        nxt(); m_drv(0, 1'b1, 2'b10, 1'b1, a0); m_drv(1, 1'b1, 2'b10, 1'b1, a1);
        smp(); chk("tie_cap_rdy0", hr(0), 1); chk("tie_cap_rdy1", hr(1), 1);
        nxt(); m_drv(0, 1'b0, 2'b00, 1'b0, 0); m_drv(1, 1'b0, 2'b00, 1'b0, 0);
        m_wd(0, d0); m_wd(1, d1);
        smp(); chk("tie_first_addr", S_HADDR, af);
        chk("tie_stall0", hr(0), 0); chk("tie_stall1", hr(1), 0);
        nxt();
        smp(); chk("tie_first_wdata", S_HWDATA, df);
        chk("tie_first_rdy", hr(first), 1); chk("tie_other_wait", hr(oth), 0);
        nxt();
        smp(); chk("tie_second_addr", S_HADDR, ao); chk("tie_second_trans", S_HTRANS, 2);
        nxt();
        smp(); chk("tie_second_wdata", S_HWDATA, dother); chk("tie_second_rdy", hr(oth), 1);
    endtask

    initial begin
        HRESETn = 1'b0;
        M0_HSEL = 0; M0_HADDR = 0; M0_HTRANS = 0; M0_HWRITE = 0; M0_HSIZE = 3'd2; M0_HBURST = 0; M0_HWDATA = 0;
        M1_HSEL = 0; M1_HADDR = 0; M1_HTRANS = 0; M1_HWRITE = 0; M1_HSIZE = 3'd2; M1_HBURST = 0; M1_HWDATA = 0;
        cfg_wait = 0; cfg_err = 1'b0;
        repeat (2) nxt();
        smp();
        chk("rst_m0_hready", M0_HREADY, 1); chk("rst_m1_hready", M1_HREADY, 1);
        chk("rst_m0_hresp", M0_HRESP, 0);   chk("rst_m0_hrdata", M0_HRDATA, 0);
        chk("rst_s_hsel", S_HSEL, 0);       chk("rst_s_htrans", S_HTRANS, 0);
        chk("rst_s_haddr", S_HADDR, 0);     chk("rst_s_hwdata", S_HWDATA, 0);
        nxt(); HRESETn = 1'b1;

        // First tie after reset: M0 wins.
        tie(32'h8, 32'h0000_0011, 32'hC, 32'h0000_0022, 0);

        // Single write and read-back through the slave.
        single(0, 1'b1, 32'h4, 32'hA5A5_0001, 32'h0);
        single(0, 1'b0, 32'h4, 32'h0, 32'hA5A5_0001);

        // M0 served last, so the next ties rotate to M1 (fixed priority: M0).
        tie(32'h20, 32'h0000_0033, 32'h24, 32'h0000_0044, RR_TIE);
        tie(32'h28, 32'h0000_0055, 32'h2C, 32'h0000_0066, RR_TIE);
        single(1, 1'b0, 32'h2C, 32'h0, 32'h0000_0066);

        // Five wait states on M0's data phase; M1 arrives and must wait.
        cfg_wait = 5;
        nxt(); m_drv(0, 1'b1, 2'b10, 1'b1, 32'h14);
        smp();
        nxt(); m_drv(0, 1'b0, 2'b00, 1'b0, 0); m_wd(0, 32'hCAFE_0014);
        m_drv(1, 1'b1, 2'b10, 1'b1, 32'h18);
        smp(); chk("ws_s_addr", S_HADDR, 32'h14); chk("ws_m1_cap_rdy", M1_HREADY, 1);
        nxt(); m_drv(1, 1'b0, 2'b00, 1'b0, 0); m_wd(1, 32'hBEEF_0018); cfg_wait = 0;
        for (int i = 0; i < 5; i++) begin
            smp();
            chk("ws_m0_wait", M0_HREADY, 0); chk("ws_m1_wait", M1_HREADY, 0);
            chk("ws_no_early_grant", S_HTRANS, 0);
            nxt();
        end
        smp(); chk("ws_m0_done", M0_HREADY, 1); chk("ws_wdata", S_HWDATA, 32'hCAFE_0014);
        nxt();
        smp(); chk("ws_m1_addr", S_HADDR, 32'h18); chk("ws_m1_stall", M1_HREADY, 0);
        nxt();
        smp(); chk("ws_m1_done", M1_HREADY, 1); chk("ws_m1_wdata", S_HWDATA, 32'hBEEF_0018);
        single(0, 1'b0, 32'h14, 32'h0, 32'hCAFE_0014);

        // Two-cycle ERROR on an M1 read; M0 stays idle and unaffected.
        cfg_err = 1'b1;
        nxt(); m_drv(1, 1'b1, 2'b10, 1'b0, 32'h10);
        smp();
        nxt(); m_drv(1, 1'b0, 2'b00, 1'b0, 0);
        smp(); chk("err_s_addr", S_HADDR, 32'h10);
        nxt(); cfg_err = 1'b0;
        smp(); chk("err1_hresp", M1_HRESP, 1); chk("err1_hready", M1_HREADY, 0);
        chk("err1_m0_hready", M0_HREADY, 1); chk("err1_m0_hresp", M0_HRESP, 0);
        nxt();
        smp(); chk("err2_hresp", M1_HRESP, 1); chk("err2_hready", M1_HREADY, 1);
        chk("err2_m0_hresp", M0_HRESP, 0);
        nxt();
        smp(); chk("err_after_hresp", M1_HRESP, 0); chk("err_after_hready", M1_HREADY, 1);

        // Reset in the middle of an M0 write data phase.
        cfg_wait = 3;
        nxt(); m_drv(0, 1'b1, 2'b10, 1'b1, 32'h1C);
        smp();
        nxt(); m_drv(0, 1'b0, 2'b00, 1'b0, 0); m_wd(0, 32'h0000_0055);
        smp(); chk("rmid_s_addr", S_HADDR, 32'h1C);
        nxt();
        smp(); chk("rmid_m0_wait", M0_HREADY, 0);
        HRESETn = 1'b0; cfg_wait = 0;
        nxt();
        smp(); chk("rmid_s_htrans", S_HTRANS, 0); chk("rmid_s_hsel", S_HSEL, 0);
        chk("rmid_m0_hready", M0_HREADY, 1); chk("rmid_m0_hresp", M0_HRESP, 0);
        chk("rmid_s_hwdata", S_HWDATA, 0);
        HRESETn = 1'b1;
        single(1, 1'b0, 32'h4, 32'h0, 32'hA5A5_0001);

        // Fresh reset state again: tie goes to M0 in both modes.
        tie(32'h30, 32'h0000_0077, 32'h34, 32'h0000_0088, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_lite_sdram_arbiter.md
Name: ahb_lite_sdram_arbiter

Overview:
- Two-master AHB-Lite arbiter in front of the single-slave ahb_lite_sdram controller.
- Each master address phase is captured in a per-master hold buffer, then replayed to the slave under round-robin arbitration.
- The owning master is stalled via its HREADY until the slave data phase completes.
- Non-pipelined on the slave side: at most one outstanding slave transfer.

Parameters:
- ADDR_W, 32, HADDR width on all ports.
- DATA_W, 32, HWDATA/HRDATA width on all ports.

Ports:
- HCLK  in  1  system clock; all logic on rising edge.
- HRESETn  in  1  synchronous, active-low reset.
- M0_HSEL, M1_HSEL  in  1  master selects the SDRAM slave.
- M0_HADDR, M1_HADDR  in  ADDR_W  address.
- M0_HTRANS, M1_HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- M0_HWRITE, M1_HWRITE  in  1  write flag.
- M0_HSIZE, M1_HSIZE  in  3  transfer size.
- M0_HBURST, M1_HBURST  in  3  burst type; forwarded unchanged.
- M0_HWDATA, M1_HWDATA  in  DATA_W  write data, valid in the master data phase.
- M0_HRDATA, M1_HRDATA  out  DATA_W  read data.
- M0_HREADY, M1_HREADY  out  1  per-master ready.
- M0_HRESP, M1_HRESP  out  1  per-master response.
- S_HSEL, S_HADDR, S_HTRANS, S_HWRITE, S_HSIZE, S_HBURST, S_HWDATA  out  as above  slave request.
- S_HRDATA  in  DATA_W  slave read data.
- S_HREADY  in  1  slave ready.
- S_HRESP  in  1  slave response.

Behaviour:
- Capture:
  - A master request is valid when Mi_HSEL=1, Mi_HTRANS[1]=1 and Mi_HREADY=1.
  - A valid request loads pend_i plus address, control and burst at the clock edge.
  - IDLE, BUSY or HSEL=0 are ignored; that master then sees HREADY=1, HRESP=0.
- Stall: while pend_i=1, Mi_HREADY=0 and Mi_HRESP=0. The master must hold HWDATA stable.
- FSM states:
  - ARB: slave idle.
    - If any pend_i is set, select the grant combinationally.
    - Drive the slave address phase from the granted buffer: S_HSEL=1, S_HTRANS=NONSEQ.
    - If S_HREADY=1, latch owner and go to DATA; otherwise hold the request and the grant.
    - With no pending request: S_HSEL=0, S_HTRANS=IDLE.
  - DATA:
    - Drive S_HWDATA from the owner's Mi_HWDATA; S_HTRANS=IDLE.
    - Route S_HRDATA, S_HREADY and S_HRESP to the owner.
    - On S_HREADY=1: clear pend_owner, set last_grant=owner, go to ARB.
    - The non-owner sees HRDATA=0.
- Round-robin:
  - Grant goes to the single pending master.
  - If both are pending, grant goes to the master that is not last_grant.
  - last_grant resets to 1, so M0 wins the first tie.
- Latency: master address phase at cycle N, slave address at N+1, slave data at N+2. With a zero-wait slave, Mi_HREADY=1 at N+2 (one stall cycle).
- Back-to-back: the owner's next request is captured in its completion cycle. The other master, if pending, wins next.
- Error: two-cycle AHB ERROR is passed through verbatim. Owner sees HRESP=1/HREADY=0, then HRESP=1/HREADY=1; pend is cleared on the second cycle.
- Simultaneous capture and completion for the same master: completion clears first, then the new capture sets pend.
- Reset (HRESETn=0 at edge), including mid-transfer:
  - State becomes ARB; pend_0 and pend_1 become 0; last_grant becomes 1.
  - Outputs: Mi_HREADY=1, Mi_HRESP=0, Mi_HRDATA=0, S_HSEL=0, S_HTRANS=IDLE. All other S_* outputs are 0.

Optional Feature:
- Macro AHB_ARB_FIXED_PRIORITY_EN.
- Defined: M0 always wins when both are pending; last_grant is unused.
- Undefined: round-robin as specified above.

Decomposition:
- Package ahb_arb_pkg holds:
  - HTRANS constants.
  - FSM state encoding (ARB, DATA).
  - Buffered-request struct type (addr, write, size, burst).
- One sub-module, ahb_lite_arb_req_buf: per-master capture/pend register plus stall logic. It is instantiated twice.

Test Plan:
- Single write: M0 NONSEQ write addr 0x4, data 0xA5A5_0001 → S_HADDR=0x4 at N+1, S_HWDATA=0xA5A5_0001 at N+2, M0_HREADY=1 at N+2. SDRAM read-back of 0x4 returns 0xA5A5_0001.
- Tie: M0 write 0x8 and M1 write 0xC in the same cycle → after reset, M0 is served first, then M1. The next tie goes to M1 first.
- Wait states: slave holds S_HREADY=0 for 5 cycles in DATA → owner HREADY stays 0 throughout. The other master remains pending and is never granted early.
- Error: S_HRESP=1 two-cycle error on an M1 read of 0x10 → M1 sees the HRESP/HREADY pair 1/0 then 1/1. M0 is unaffected.
- Reset mid-DATA: assert HRESETn=0 during an M0 write → next edge gives S_HTRANS=IDLE, M0_HREADY=1, pend cleared. A fresh M1 read of 0x4 then completes normally.
- AHB_ARB_FIXED_PRIORITY_EN defined: three consecutive ties → M0 is granted every time.
